// File: rtl/v0_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : v0_display_scanner
//  Description : Four-digit multiplexed 7-segment scanner for the CPU $v0
//                register. Shows one 16-bit page of a 32-bit value as hex,
//                with optional leading-zero blanking and an upper-page
//                indicator on the leftmost decimal point.
//  Revision    : 1.0 - initial release
// ============================================================================
module v0_display_scanner #(
  parameter int REFRESH_DIV = 50000,  // clock cycles per digit slot
  parameter int BLANK_LZ    = 1       // 1: blank leading zero digits
) (
  input  logic        CLK_IN,
  input  logic        GLOBALRESET,
  input  logic [31:0] value_in,
  input  logic        page_in,
  output logic [3:0]  digit_out,
  output logic [6:0]  seg_out,
  output logic        dp_out
);

  localparam int              c_PW   = $clog2(REFRESH_DIV);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(REFRESH_DIV - 1);
  localparam logic [6:0]      c_SEG_BLANK = 7'b1111111;

  logic [c_PW-1:0] r_presc;
  logic [1:0]      r_index;
  logic [31:0]     r_snap_val;
  logic            r_snap_page;

  logic            w_tick;
  logic [15:0]     w_hw;
  logic [3:0]      w_nibble;
  logic            w_upper_zero;
  logic            w_blank;
  logic [6:0]      w_seg_hex;

  assign w_tick = (r_presc == c_LAST);

  // Prescaler: one tick per digit slot.
  always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
    if (!GLOBALRESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit index walks 0..3 and wraps naturally in two bits.
  always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
    if (!GLOBALRESET) begin
      r_index <= 2'd0;
    end else if (w_tick) begin
      r_index <= r_index + 2'd1;
    end
  end

  // Snapshot taken only at the frame boundary so a frame never mixes data.
  always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
    if (!GLOBALRESET) begin
      r_snap_val  <= 32'd0;
      r_snap_page <= 1'b0;
    end else if (w_tick && (r_index == 2'd3)) begin
      r_snap_val  <= value_in;
      r_snap_page <= page_in;
    end
  end

  assign w_hw = r_snap_page ? r_snap_val[31:16] : r_snap_val[15:0];

  // Select the nibble for the current digit and test the digits at and above it.
  always_comb begin
    w_nibble     = w_hw[3:0];
    w_upper_zero = 1'b0;
    case (r_index)
      2'd0: begin
        w_nibble     = w_hw[3:0];
        w_upper_zero = 1'b0;       // digit 0 is never blanked
      end
      2'd1: begin
        w_nibble     = w_hw[7:4];
        w_upper_zero = (w_hw[15:4] == 12'd0);
      end
      2'd2: begin
        w_nibble     = w_hw[11:8];
        w_upper_zero = (w_hw[15:8] == 8'd0);
      end
      default: begin
        w_nibble     = w_hw[15:12];
        w_upper_zero = (w_hw[15:12] == 4'd0);
      end
    endcase
  end

  assign w_blank = (BLANK_LZ != 0) && w_upper_zero;

  // Active-low hex decode, segment order {a,b,c,d,e,f,g}.
  always_comb begin
    w_seg_hex = c_SEG_BLANK;
    case (w_nibble)
      4'h0: w_seg_hex = 7'b0000001;
      4'h1: w_seg_hex = 7'b1001111;
      4'h2: w_seg_hex = 7'b0010010;
      4'h3: w_seg_hex = 7'b0000110;
      4'h4: w_seg_hex = 7'b1001100;
      4'h5: w_seg_hex = 7'b0100100;
      4'h6: w_seg_hex = 7'b0100000;
      4'h7: w_seg_hex = 7'b0001111;
      4'h8: w_seg_hex = 7'b0000000;
      4'h9: w_seg_hex = 7'b0000100;
      4'hA: w_seg_hex = 7'b0001000;
      4'hB: w_seg_hex = 7'b1100000;
      4'hC: w_seg_hex = 7'b0110001;
      4'hD: w_seg_hex = 7'b1000010;
      4'hE: w_seg_hex = 7'b0110000;
      default: w_seg_hex = 7'b0111000;
    endcase
  end

  // Outputs depend only on registered state; the decimal point flags the upper page.
  always_comb begin
    digit_out = ~(4'b0001 << r_index);
    seg_out   = w_blank ? c_SEG_BLANK : w_seg_hex;
    dp_out    = ~((r_index == 2'd3) && r_snap_page);
  end

endmodule
`default_nettype wire

// File: tb/tb_v0_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_v0_display_scanner
//  Description : Self-checking bench for v0_display_scanner. Two instances
//                (blanking on / off) share stimulus and are compared every
//                cycle against a cycle-count based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_v0_display_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value_in;
  logic        page_in;

  logic [3:0]  dig_b, dig_f;
  logic [6:0]  seg_b, seg_f;
  logic        dp_b, dp_f;

  v0_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) u_dut_blank (
    .CLK_IN      (clk),
    .GLOBALRESET (rst_n),
    .value_in    (value_in),
    .page_in     (page_in),
    .digit_out   (dig_b),
    .seg_out     (seg_b),
    .dp_out      (dp_b)
  );

  v0_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) u_dut_full (
    .CLK_IN      (clk),
    .GLOBALRESET (rst_n),
    .value_in    (value_in),
    .page_in     (page_in),
    .digit_out   (dig_f),
    .seg_out     (seg_f),
    .dp_out      (dp_f)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cycles elapsed since reset release plus the frame snapshot.
  int          m_cycle;
  logic [31:0] m_snap_val;
  logic        m_snap_page;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] hex_seg(input int n);
    case (n)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100; 10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input bit blank_lz);
    int hw;
    int upper;
    hw    = m_snap_page ? int'(m_snap_val[31:16]) : int'(m_snap_val[15:0]);
    upper = hw >> (4 * idx);
    if (blank_lz && idx > 0 && upper == 0) return 7'b1111111;
    return hex_seg(upper & 15);
  endfunction

  task automatic model_reset();
    m_cycle     = 0;
    m_snap_val  = 32'd0;
    m_snap_page = 1'b0;
  endtask

  task automatic check_outputs();
    int         idx;
    logic [3:0] ed;
    logic       edp;
    idx     = (m_cycle / DIV) % 4;
    ed      = 4'b1111;
    ed[idx] = 1'b0;
    edp     = !(idx == 3 && m_snap_page);
    check("digit_blank", 32'(dig_b), 32'(ed));
    check("digit_full",  32'(dig_f), 32'(ed));
    check("seg_blank",   32'(seg_b), 32'(exp_seg(idx, 1'b1)));
    check("seg_full",    32'(seg_f), 32'(exp_seg(idx, 1'b0)));
    check("dp_blank",    32'(dp_b),  32'(edp));
    check("dp_full",     32'(dp_f),  32'(edp));
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (m_cycle % FRAME == FRAME - 1) begin
        m_snap_val  = value_in;
        m_snap_page = page_in;
      end
      m_cycle++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_literals();
    check("rst_digit", 32'(dig_b), 32'(4'b1110));
    check("rst_seg",   32'(seg_f), 32'(7'b0000001));
    check("rst_dp",    32'(dp_b),  32'(1'b1));
  endtask

  // Reset asserted at a falling edge, held over len rising edges.
  task automatic pulse_reset(input int len);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_literals();
    check_outputs();
    repeat (len) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    value_in = 32'd0;
    page_in  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_literals();
    check_outputs();

    // First frame shows the reset snapshot, second shows 1,2,3,4.
    value_in = 32'h0000_1234;
    rst_n    = 1'b1;
    run(2 * FRAME);

    // Leading-zero blanking on one instance, full decode on the other.
    value_in = 32'h0000_0050;
    run(2 * FRAME);

    // Upper page with decimal point, then lower page of the same value.
    value_in = 32'hABCD_0000;
    page_in  = 1'b1;
    run(2 * FRAME);
    page_in  = 1'b0;
    run(2 * FRAME);

    // Input changed mid-frame must not tear the displayed frame.
    value_in = 32'h0000_1111;
    run(2 * FRAME);
    run(DIV + 1);
    value_in = 32'h0000_2222;
    check("tear_seg", 32'(seg_f), 32'(7'b1001111));
    run(FRAME - DIV - 1 + FRAME);

    // Reset pulse in the index-2 slot with a nonzero snapshot.
    value_in = 32'h0000_9876;
    run(FRAME + 2 * DIV + 1);
    pulse_reset(1);
    run(3);
    check("rel_idx0", 32'(dig_b), 32'(4'b1110));
    step();
    check("rel_idx1", 32'(dig_b), 32'(4'b1101));

    // Randomized values, pages, dwell times and occasional resets.
    for (int k = 0; k < 60; k++) begin
      value_in = $urandom;
      if ($urandom_range(0, 1) == 1) value_in = value_in >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) value_in = value_in & 32'h00F0_00F0;
      page_in = 1'($urandom_range(0, 1));
      run($urandom_range(1, 2 * FRAME));
      if ($urandom_range(0, 14) == 0) pulse_reset($urandom_range(1, 3));
    end
    run(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
